// File: rtl/ahb_sngl_master.sv
// ahb_sngl_master: AHB-Lite initiator issuing one single transfer per local command
module ahb_sngl_master #(
  parameter int wcnt_w = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [wcnt_w-1:0] rsp_wcnt,
  output logic [31:0]       haddr,
  output logic [31:0]       hwdata,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  input  logic [31:0]       hrdata,
  input  logic [1:0]        hresp,
  input  logic              hready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic [31:0] wrep, lane, sh_b, sh_h;
  logic [1:0] htrans_q, htrans_d;
  logic [2:0] hsize_q, hsize_d;
  logic hwrite_q, hwrite_d, valid_q, valid_d, err_q, err_d, accept, legal, bus_err;
  logic [wcnt_w-1:0] wcnt_q, wcnt_d;
  assign cmd_ready = state_q == IDLE;
  assign accept    = cmd_valid & cmd_ready;
  assign legal     = (cmd_size == 3'd0) | (cmd_size == 3'd1 & ~cmd_addr[0]) | (cmd_size == 3'd2 & cmd_addr[1:0] == 2'b00);
  assign bus_err   = hresp != 2'b00;
  assign wrep      = cmd_size == 3'd0 ? {4{cmd_wdata[7:0]}} : cmd_size == 3'd1 ? {2{cmd_wdata[15:0]}} : cmd_wdata;
  assign sh_b      = hrdata >> {haddr_q[1:0], 3'b000};
  assign sh_h      = hrdata >> {haddr_q[1], 4'b0000};
  assign lane      = hsize_q == 3'd0 ? {24'h0, sh_b[7:0]} : hsize_q == 3'd1 ? {16'h0, sh_h[15:0]} : hrdata;
  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;
  assign hwrite    = hwrite_q;
  assign htrans    = htrans_q;
  assign hsize     = hsize_q;
  assign hburst    = 3'b000;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_wcnt  = wcnt_q;
  // next state, bus phase registers and response capture
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: if (accept) begin
        wcnt_d  = '0;
        rdata_d = '0;
        err_d   = ~legal;
        if (legal) begin
          state_d  = ADDR;
          haddr_d  = cmd_addr;
          hwdata_d = wrep;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          htrans_d = 2'b10;
        end else begin
          state_d = RESP;
          valid_d = 1'b1;
        end
      end
      ADDR: if (hready) begin
        state_d  = DATA;
        htrans_d = 2'b00;
      end
      DATA: if (!hready) begin
        wcnt_d = &wcnt_q ? wcnt_q : wcnt_q + wcnt_w'(1);
      end else begin
        state_d = RESP;
        valid_d = 1'b1;
        err_d   = bus_err;
        rdata_d = (bus_err | hwrite_q) ? 32'h0 : lane;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously so the bus goes idle at once
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= 2'b00;
      hsize_q  <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_ahb_sngl_master.sv
// tb_ahb_sngl_master: directed transfers checked against a transaction-level model
module tb_ahb_sngl_master;
  logic hclk = 1'b0, hresetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, hready = 1'b1;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, hrdata = '0;
  logic [2:0] cmd_size = '0;
  logic [1:0] hresp = '0;
  logic cmd_ready, rsp_valid, rsp_err, hwrite;
  logic [31:0] rsp_rdata, haddr, hwdata;
  logic [7:0] rsp_wcnt;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  int n_chk = 0, n_err = 0;
  logic [31:0] last_rd, last_hw;
  logic [7:0] last_wc;
  logic last_err;

  ahb_sngl_master dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_wcnt(rsp_wcnt),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  always #5 hclk = ~hclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [31:0] a, input logic [2:0] sz);
    return sz <= 3'd2 && (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] wd, input logic [2:0] sz);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] bus, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] r = '0;
    int off = int'(a[1:0]);
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = bus[8*(off+i) +: 8];
    return r;
  endfunction

  // one clock; protocol invariants checked at every negedge
  task automatic tick();
    logic pv = rsp_valid, pr = rsp_ready, pe = rsp_err;
    logic [31:0] prd = rsp_rdata;
    logic [7:0] pw = rsp_wcnt;
    @(posedge hclk);
    @(negedge hclk);
    if (hresetn) begin
      chk("hburst", 32'(hburst), 32'd0);
      if (pv && !pr) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, prd);
        chk("hold_err", 32'(rsp_err), 32'(pe));
        chk("hold_wcnt", 32'(rsp_wcnt), 32'(pw));
      end
      if (pv && pr) chk("valid_clear", 32'(rsp_valid), 32'd0);
      if (cmd_ready) begin
        chk("idle_htrans", 32'(htrans), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                     input int aw, input int w, input logic er, input logic [31:0] bus, input int hold);
    logic ok = legal(a, sz);
    logic [31:0] exp_rd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    hready = 1'b1; hresp = 2'b00;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    if (!ok) begin
      chk("ill_htrans", 32'(htrans), 32'd0);
      chk("ill_valid", 32'(rsp_valid), 32'd1);
      chk("ill_err", 32'(rsp_err), 32'd1);
      chk("ill_rdata", rsp_rdata, 32'd0);
      chk("ill_wcnt", 32'(rsp_wcnt), 32'd0);
    end else begin
      for (int i = 0; i <= aw; i++) begin
        chk("addr_htrans", 32'(htrans), 32'h2);
        chk("addr_haddr", haddr, a);
        chk("addr_hwrite", 32'(hwrite), 32'(wr));
        chk("addr_hsize", 32'(hsize), 32'(sz));
        chk("addr_cmd_ready", 32'(cmd_ready), 32'd0);
        hready = (i == aw);
        tick();
      end
      for (int i = 0; i <= w; i++) begin
        chk("data_htrans", 32'(htrans), 32'd0);
        chk("data_haddr", haddr, a);
        chk("data_rsp_valid", 32'(rsp_valid), 32'd0);
        if (wr) chk("data_hwdata", hwdata, rep(wd, sz));
        last_hw = hwdata;
        hready = (i == w);
        hresp = (er && i >= w - 1) ? 2'b01 : 2'b00;
        hrdata = (i == w) ? bus : $urandom;
        tick();
      end
      hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
      exp_rd = (er || wr) ? 32'd0 : extract(bus, a, sz);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(er));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_wcnt", 32'(rsp_wcnt), w > 255 ? 32'd255 : 32'(w));
    end
    last_rd = rsp_rdata; last_wc = rsp_wcnt; last_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_htrans", 32'(htrans), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wcnt", 32'(rsp_wcnt), 32'd0);
    @(negedge hclk); hresetn = 1'b1;
    tick();
    txn(1'b1, 32'h0000_0000, 3'd2, 32'h0000_00A5, 0, 0, 1'b0, 32'h0, 0);
    chk("lit_wr_hwdata", last_hw, 32'h0000_00A5);
    chk("lit_wr_wcnt", 32'(last_wc), 32'd0);
    txn(1'b0, 32'h0001_0000, 3'd2, 32'h0, 0, 3, 1'b0, 32'h1234_5678, 0);
    chk("lit_rd_word", last_rd, 32'h1234_5678);
    chk("lit_rd_wcnt", 32'(last_wc), 32'd3);
    txn(1'b0, 32'h0002_0003, 3'd0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    chk("lit_rd_byte3", last_rd, 32'h0000_00DE);
    txn(1'b0, 32'h0002_0002, 3'd1, 32'h0, 0, 1, 1'b0, 32'hDEAD_BEEF, 0);
    chk("lit_rd_half2", last_rd, 32'h0000_DEAD);
    txn(1'b0, 32'h0002_0001, 3'd0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    chk("lit_rd_byte1", last_rd, 32'h0000_00BE);
    txn(1'b0, 32'h0002_0000, 3'd1, 32'h0, 1, 0, 1'b0, 32'hDEAD_BEEF, 0);
    chk("lit_rd_half0", last_rd, 32'h0000_BEEF);
    txn(1'b1, 32'h0002_0001, 3'd0, 32'hFFFF_FF3C, 0, 0, 1'b0, 32'h0, 0);
    chk("lit_wr_byte", last_hw, 32'h3C3C_3C3C);
    txn(1'b1, 32'h0000_0006, 3'd1, 32'h1234_ABCD, 2, 2, 1'b0, 32'h0, 0);
    chk("lit_wr_half", last_hw, 32'hABCD_ABCD);
    txn(1'b0, 32'h0004_0000, 3'd2, 32'h0, 0, 1, 1'b1, 32'hFFFF_FFFF, 0);
    chk("lit_err_flag", 32'(last_err), 32'd1);
    chk("lit_err_wcnt", 32'(last_wc), 32'd1);
    chk("lit_err_rdata", last_rd, 32'd0);
    txn(1'b1, 32'h0000_0010, 3'd2, 32'h5555_AAAA, 0, 3, 1'b1, 32'h0, 2);
    txn(1'b1, 32'h0000_0002, 3'd2, 32'h1, 0, 0, 1'b0, 32'h0, 2);
    txn(1'b0, 32'h0000_0000, 3'd3, 32'h0, 0, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h0000_0001, 3'd1, 32'h0, 0, 0, 1'b0, 32'h0, 0);
    chk("lit_ill_err", 32'(last_err), 32'd1);
    txn(1'b0, 32'h0003_0004, 3'd2, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, 5);
    chk("lit_hold_rdata", last_rd, 32'hCAFE_F00D);
    txn(1'b0, 32'h0003_0008, 3'd2, 32'h0, 0, 300, 1'b0, 32'h0BAD_C0DE, 0);
    chk("lit_sat_wcnt", 32'(last_wc), 32'd255);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_size = 3'd2;
    tick();
    cmd_valid = 1'b0; hready = 1'b1;
    tick();
    hready = 1'b0;
    chk("rst_pre_data", 32'(htrans), 32'd0);
    tick();
    chk("rst_pre_busy", 32'(cmd_ready), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("arst_htrans", 32'(htrans), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_wcnt", 32'(rsp_wcnt), 32'd0);
    @(negedge hclk); hresetn = 1'b1; hready = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h0000_0203, 3'd0, 32'h0, 0, 0, 1'b0, 32'h7700_0000, 0);
    chk("lit_post_rst_rd", last_rd, 32'h0000_0077);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
